// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR voter: lane indices, operating modes,
// the bitwise majority primitive and run-counter width sizing.
package tmr_pkg;

    localparam int LANE_A    = 0;
    localparam int LANE_B    = 1;
    localparam int LANE_C    = 2;
    localparam int NUM_LANES = 3;

    typedef enum logic {
        MODE_TMR      = 1'b0,
        MODE_DEGRADED = 1'b1
    } mode_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Run counters must hold 0..thresh inclusive.
    function automatic int run_width(input int thresh);
        return (thresh < 1) ? 1 : $clog2(thresh + 1);
    endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Per-lane run counter: counts consecutive valid samples where this lane is
// the sole minority and flags the sample whose increment reaches the threshold.
module tmr_lane_monitor #(
    parameter int FAIL_THRESH = 8,
    parameter int RUN_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic soleMinority,
    input  logic agree,
    input  logic advance,
    input  logic clr,
    output logic thresholdHit
);

    localparam logic [RUN_W-1:0] THRESH = RUN_W'(FAIL_THRESH);

    logic [RUN_W-1:0] runCnt;
    logic [RUN_W-1:0] incCnt;

    assign incCnt       = runCnt + RUN_W'(1);
    assign thresholdHit = advance && soleMinority && (incCnt == THRESH);

    // Samples where the lane is neither sole minority nor agreeing leave the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            runCnt <= '0;
        end else if (clr) begin
            runCnt <= '0;
        end else if (advance) begin
            if (soleMinority) begin
                if (runCnt != THRESH) begin
                    runCnt <= incCnt;
                end
            end else if (agree) begin
                runCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tmr_voter_monitor.sv
// Registered TMR voter with disagreement classification, per-lane fault run
// tracking, single-lane retirement and degraded 2-of-2 compare mode.
module tmr_voter_monitor
    import tmr_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int CNT_W       = 16,
    parameter int FAIL_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    input  logic             inValid,
    input  logic             clrErr,
    output logic [WIDTH-1:0] out,
    output logic             outValid,
    output logic             tmrErr,
    output logic [2:0]       laneFault,
    output logic             multiErr,
    output logic [2:0]       laneFailed,
    output logic [CNT_W-1:0] errCnt
);

    localparam int RUN_W = run_width(FAIL_THRESH);

    mode_e            mode;
    logic [WIDTH-1:0] maj;
    logic [2:0]       diff;
    logic             diffMulti;
    logic [WIDTH-1:0] pairX;
    logic [WIDTH-1:0] pairY;
    logic [WIDTH-1:0] nextOut;
    logic             nextErr;
    logic [2:0]       nextFault;
    logic             nextMulti;
    logic [2:0]       agreeVec;
    logic [2:0]       hitVec;
    logic [2:0]       failSel;
    logic             advance;

    assign mode = (laneFailed != 3'b000) ? MODE_DEGRADED : MODE_TMR;

    // Bitwise vote and per-lane disagreement against the majority.
    always_comb begin
        maj = '0;
        for (int i = 0; i < WIDTH; i++) begin
            maj[i] = maj3(inA[i], inB[i], inC[i]);
        end
        diff[LANE_A] = (inA != maj);
        diff[LANE_B] = (inB != maj);
        diff[LANE_C] = (inC != maj);
        diffMulti    = maj3(diff[LANE_A], diff[LANE_B], diff[LANE_C]);
    end

    // In degraded mode the two surviving lanes are compared directly.
    always_comb begin
        pairX     = inA;
        pairY     = inB;
        nextOut   = out;
        nextErr   = 1'b0;
        nextFault = 3'b000;
        nextMulti = 1'b0;
        if (laneFailed[LANE_A]) begin
            pairX = inB;
            pairY = inC;
        end else if (laneFailed[LANE_B]) begin
            pairY = inC;
        end
        if (mode == MODE_TMR) begin
            nextOut   = maj;
            nextErr   = |diff;
            nextMulti = diffMulti;
            nextFault = diffMulti ? 3'b000 : diff;
        end else if (pairX == pairY) begin
            nextOut = pairX;
        end else begin
            nextErr   = 1'b1;
            nextMulti = 1'b1;
        end
    end

    assign advance  = inValid && (mode == MODE_TMR) && !clrErr;
    assign agreeVec = ~diff & {3{~diffMulti}};

    for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
        tmr_lane_monitor #(
            .FAIL_THRESH(FAIL_THRESH),
            .RUN_W      (RUN_W)
        ) laneMon (
            .clk         (clk),
            .rst         (rst),
            .soleMinority(nextFault[g]),
            .agree       (agreeVec[g]),
            .advance     (advance),
            .clr         (clrErr),
            .thresholdHit(hitVec[g])
        );
    end

    // Only the lowest-index lane is retired if several hit together.
    always_comb begin
        failSel = 3'b000;
        if (hitVec[LANE_A]) begin
            failSel = 3'b001;
        end else if (hitVec[LANE_B]) begin
            failSel = 3'b010;
        end else if (hitVec[LANE_C]) begin
            failSel = 3'b100;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out        <= '0;
            outValid   <= 1'b0;
            tmrErr     <= 1'b0;
            laneFault  <= 3'b000;
            multiErr   <= 1'b0;
            laneFailed <= 3'b000;
            errCnt     <= '0;
        end else begin
            outValid <= inValid;
            if (inValid) begin
                out       <= nextOut;
                tmrErr    <= nextErr;
                laneFault <= nextFault;
                multiErr  <= nextMulti;
            end else begin
                tmrErr    <= 1'b0;
                laneFault <= 3'b000;
                multiErr  <= 1'b0;
            end
            if (clrErr) begin
                errCnt     <= '0;
                laneFailed <= 3'b000;
            end else begin
                if (inValid && nextErr && (errCnt != {CNT_W{1'b1}})) begin
                    errCnt <= errCnt + CNT_W'(1);
                end
                if (failSel != 3'b000) begin
                    laneFailed <= failSel;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Directed bench for tmr_voter_monitor: a vector table for single-sample
// behaviour plus sequences for lane retirement, degraded mode, clear and reset.
module tb_tmr_voter_monitor;

    logic       clk;
    logic       rst;
    logic [7:0] inA;
    logic [7:0] inB;
    logic [7:0] inC;
    logic       inValid;
    logic       clrErr;

    logic [7:0]  out;
    logic        outValid;
    logic        tmrErr;
    logic [2:0]  laneFault;
    logic        multiErr;
    logic [2:0]  laneFailed;
    logic [15:0] errCnt;

    logic [7:0]  out2;
    logic        outValid2;
    logic        tmrErr2;
    logic [2:0]  laneFault2;
    logic        multiErr2;
    logic [2:0]  laneFailed2;
    logic [1:0]  errCnt2;

    int nChecks = 0;
    int nFail   = 0;
    int ecExp   = 0;

    tmr_voter_monitor #(.WIDTH(8), .CNT_W(16), .FAIL_THRESH(8)) dut (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
        .inValid(inValid), .clrErr(clrErr), .out(out), .outValid(outValid),
        .tmrErr(tmrErr), .laneFault(laneFault), .multiErr(multiErr),
        .laneFailed(laneFailed), .errCnt(errCnt)
    );

    tmr_voter_monitor #(.WIDTH(8), .CNT_W(2), .FAIL_THRESH(8)) dutSat (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
        .inValid(inValid), .clrErr(clrErr), .out(out2), .outValid(outValid2),
        .tmrErr(tmrErr2), .laneFault(laneFault2), .multiErr(multiErr2),
        .laneFailed(laneFailed2), .errCnt(errCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a, b, c;
        logic        v;
        logic [7:0]  eOut;
        logic        eOv, eErr;
        logic [2:0]  eFault;
        logic        eMulti;
        logic [2:0]  eFailed;
        logic [15:0] eEc;
    } vec_t;

    vec_t vecs[6];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                 input logic v, input logic clr);
        @(negedge clk);
        inA = a; inB = b; inC = c; inValid = v; clrErr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eOut, input logic eOv,
                               input logic eErr, input logic [2:0] eFault, input logic eMulti,
                               input logic [2:0] eFailed, input logic [15:0] eEc);
        cmp({name, ".out"}, out, eOut);
        cmp({name, ".outValid"}, outValid, eOv);
        cmp({name, ".tmrErr"}, tmrErr, eErr);
        cmp({name, ".laneFault"}, laneFault, eFault);
        cmp({name, ".multiErr"}, multiErr, eMulti);
        cmp({name, ".laneFailed"}, laneFailed, eFailed);
        cmp({name, ".errCnt"}, errCnt, eEc);
    endtask

    // One valid/clear sample with the running errCnt model.
    task automatic stepCheck(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic v, input logic clr,
                             input logic [7:0] eOut, input logic eErr, input logic [2:0] eFault,
                             input logic eMulti, input logic [2:0] eFailed);
        if (clr) ecExp = 0;
        else if (v && eErr) ecExp++;
        applyStimulus(a, b, c, v, clr);
        checkOutput(name, eOut, v, eErr, eFault, eMulti, eFailed, 16'(ecExp));
    endtask

    initial begin
        rst = 1'b1; inA = '0; inB = '0; inC = '0; inValid = 1'b0; clrErr = 1'b0;

        //              a      b      c     v  eOut  ov err fault   m  failed  ec
        vecs[0] = '{8'h5A, 8'h5A, 8'h5A, 1, 8'h5A, 1, 0, 3'b000, 0, 3'b000, 16'd0};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 1, 8'h00, 1, 1, 3'b010, 0, 3'b000, 16'd1};
        vecs[2] = '{8'h77, 8'h77, 8'h77, 0, 8'h00, 0, 0, 3'b000, 0, 3'b000, 16'd1};
        vecs[3] = '{8'h01, 8'h02, 8'h00, 1, 8'h00, 1, 1, 3'b000, 1, 3'b000, 16'd2};
        vecs[4] = '{8'h0F, 8'h0F, 8'hF0, 1, 8'h0F, 1, 1, 3'b100, 0, 3'b000, 16'd3};
        vecs[5] = '{8'h3C, 8'h3C, 8'h3C, 1, 8'h3C, 1, 0, 3'b000, 0, 3'b000, 16'd3};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 8'h00, 0, 0, 3'b000, 0, 3'b000, 16'd0);
        cmp("reset.errCnt2", errCnt2, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].v, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].eOut, vecs[i].eOv, vecs[i].eErr,
                        vecs[i].eFault, vecs[i].eMulti, vecs[i].eFailed, vecs[i].eEc);
        end
        ecExp = 3;

        // A multiErr sample between C-minority runs must hold C's run count.
        for (int i = 0; i < 3; i++)
            stepCheck($sformatf("holdPre%0d", i), 8'h00, 8'h00, 8'h01, 1, 0, 8'h00, 1, 3'b100, 0, 3'b000);
        stepCheck("holdMulti", 8'h01, 8'h02, 8'h00, 1, 0, 8'h00, 1, 3'b000, 1, 3'b000);
        for (int i = 0; i < 5; i++)
            stepCheck($sformatf("holdPost%0d", i), 8'h00, 8'h00, 8'h01, 1, 0, 8'h00, 1, 3'b100, 0,
                      (i == 4) ? 3'b100 : 3'b000);

        stepCheck("clrIdle", 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 0, 3'b000, 0, 3'b000);

        for (int i = 0; i < 7; i++)
            stepCheck($sformatf("runA%0d", i), 8'h00, 8'h00, 8'h01, 1, 0, 8'h00, 1, 3'b100, 0, 3'b000);
        stepCheck("agree", 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 3'b000, 0, 3'b000);
        for (int i = 0; i < 8; i++)
            stepCheck($sformatf("runB%0d", i), 8'h00, 8'h00, 8'h01, 1, 0, 8'h00, 1, 3'b100, 0,
                      (i == 7) ? 3'b100 : 3'b000);

        stepCheck("degMis", 8'h11, 8'h22, 8'h11, 1, 0, 8'h00, 1, 3'b000, 1, 3'b100);
        stepCheck("degEq", 8'h33, 8'h33, 8'hFF, 1, 0, 8'h33, 0, 3'b000, 0, 3'b100);
        stepCheck("degEq2", 8'h44, 8'h44, 8'h00, 1, 0, 8'h44, 0, 3'b000, 0, 3'b100);
        stepCheck("degClr", 8'h11, 8'h22, 8'h33, 1, 1, 8'h44, 1, 3'b000, 1, 3'b000);
        cmp("degClr.errCnt2", errCnt2, 0);

        for (int i = 0; i < 5; i++) begin
            stepCheck($sformatf("sat%0d", i), 8'h00, 8'hFF, 8'h00, 1, 0, 8'h00, 1, 3'b010, 0, 3'b000);
            cmp($sformatf("sat%0d.errCnt2", i), errCnt2, (i < 3) ? i + 1 : 3);
        end
        stepCheck("satClr", 8'h00, 8'hFF, 8'h00, 1, 1, 8'h00, 1, 3'b010, 0, 3'b000);
        cmp("satClr.errCnt2", errCnt2, 0);

        // B's run count was cleared, so it needs a full fresh run to fail.
        for (int i = 0; i < 8; i++)
            stepCheck($sformatf("runBl%0d", i), 8'h00, 8'hFF, 8'h00, 1, 0, 8'h00, 1, 3'b010, 0,
                      (i == 7) ? 3'b010 : 3'b000);

        @(negedge clk);
        inA = 8'h00; inB = 8'h00; inC = 8'h01; inValid = 1'b1; clrErr = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rstMid", 8'h00, 0, 0, 3'b000, 0, 3'b000, 16'd0);
        cmp("rstMid.errCnt2", errCnt2, 0);
        @(negedge clk);
        rst = 1'b0;
        inValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstAfter", 8'h00, 0, 0, 3'b000, 0, 3'b000, 16'd0);
        ecExp = 0;
        stepCheck("rstResume", 8'h5A, 8'h5A, 8'h5A, 1, 0, 8'h5A, 0, 3'b000, 0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
